// File: rtl/core_pkg.sv
// Shared core types: register/data widths and the writeback request record.
package core_pkg;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    localparam logic [AW-1:0] REG_ZERO = '0;
endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO for load-return writebacks; exposes every slot and its
// occupancy flag so the owner can build a pending-destination mask.
module wb_fifo
    import core_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  wb_req_t               din,
    output wb_req_t               dout,
    output logic                  full,
    output logic                  empty,
    output logic [CW-1:0]         count,
    output wb_req_t [DEPTH-1:0]   entries,
    output logic [DEPTH-1:0]      entry_valid
);
    wb_req_t       mem_reg [DEPTH];
    logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic          do_push, do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_reg[rd_ptr_reg];
    assign count   = count_reg;
    assign count_next = count_reg + CW'(do_push) - CW'(do_pop);

    // A slot is live when its distance from the head is below the occupancy.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic [PW-1:0] offs;
        assign offs            = PW'(gi) - rd_ptr_reg;
        assign entries[gi]     = mem_reg[gi];
        assign entry_valid[gi] = ({1'b0, offs} < count_reg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_reg[wr_ptr_reg] <= din;
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port master: ALU results win unless the load queue is
// full, queued loads drain in order, and queued destinations are exported.
module rf_wb_arbiter #(
    parameter  int XLEN     = core_pkg::XLEN,
    parameter  int AW       = core_pkg::AW,
    parameter  int LQ_DEPTH = 4,
    localparam int CW       = $clog2(LQ_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [AW-1:0]     alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [AW-1:0]     ld_rd,
    input  logic [XLEN-1:0]   ld_data,
    output logic              rf_we,
    output logic [AW-1:0]     rf_rd_addr,
    output logic [XLEN-1:0]   rf_rd_data,
    output logic [2**AW-1:0]  pend_mask,
    output logic [CW-1:0]     lq_count
);
    core_pkg::wb_req_t                  ld_req, alu_req, head;
    core_pkg::wb_req_t [LQ_DEPTH-1:0]   lq_entries;
    logic [LQ_DEPTH-1:0]                lq_valid;
    logic                               lq_full, lq_empty;
    logic                               alu_grant, lq_grant;

    assign ld_req  = '{rd: ld_rd, data: ld_data};
    assign alu_req = '{rd: alu_rd, data: alu_data};

    wb_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (ld_valid),
        .pop         (lq_grant),
        .din         (ld_req),
        .dout        (head),
        .full        (lq_full),
        .empty       (lq_empty),
        .count       (lq_count),
        .entries     (lq_entries),
        .entry_valid (lq_valid)
    );

    // A full queue takes the port so loads can never be starved by the ALU.
    assign alu_ready = !lq_full;
    assign ld_ready  = !lq_full;
    assign alu_grant = alu_valid && !lq_full;
    assign lq_grant  = !alu_grant && !lq_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we      <= 1'b0;
            rf_rd_addr <= '0;
            rf_rd_data <= '0;
        end else if (alu_grant) begin
            rf_we      <= (alu_req.rd != core_pkg::REG_ZERO);
            rf_rd_addr <= alu_req.rd;
            rf_rd_data <= alu_req.data;
        end else if (lq_grant) begin
            rf_we      <= (head.rd != core_pkg::REG_ZERO);
            rf_rd_addr <= head.rd;
            rf_rd_data <= head.data;
        end else begin
            rf_we      <= 1'b0;
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (lq_valid[i]) pend_mask[lq_entries[i].rd] = 1'b1;
        end
        pend_mask[core_pkg::REG_ZERO] = 1'b0;
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed plus randomized bench for rf_wb_arbiter against a queue-based model.
module tb_rf_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, alu_ready, ld_valid, ld_ready;
    logic [4:0]  alu_rd, ld_rd, rf_rd_addr;
    logic [31:0] alu_data, ld_data, rf_rd_data, pend_mask;
    logic        rf_we;
    logic [2:0]  lq_count;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        lq[$];
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    int          total = 0;
    int          bad = 0;
    int          model_ld_wr = 0;
    int          dut_ld_wr = 0;

    rf_wb_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .rf_we      (rf_we),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .pend_mask  (pend_mask),
        .lq_count   (lq_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (lq[i]) m[lq[i].rd] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    // One clock: drive, check readys, advance the model, check registered outputs.
    task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] adat,
                        input bit lv, input logic [4:0] lrd, input logic [31:0] ldat);
        bit   full;
        bit   ld_win;
        ent_t e;
        alu_valid = av; alu_rd = ard; alu_data = adat;
        ld_valid  = lv; ld_rd  = lrd; ld_data  = ldat;
        full   = (lq.size() == 4);
        ld_win = 1'b0;
        chk("alu_ready", alu_ready, !full);
        chk("ld_ready", ld_ready, !full);
        if (!full && av) begin
            exp_we = (ard != 0); exp_addr = ard; exp_data = adat;
        end else if (lq.size() > 0) begin
            e = lq.pop_front();
            exp_we = (e.rd != 0); exp_addr = e.rd; exp_data = e.data;
            ld_win = 1'b1;
        end else begin
            exp_we = 1'b0;
        end
        if (lv && !full) lq.push_back('{rd: lrd, data: ldat});
        if (ld_win && exp_we) model_ld_wr++;
        @(posedge clk); #1;
        if (rf_we === 1'b1 && ld_win) dut_ld_wr++;
        chk("rf_we", rf_we, exp_we);
        chk("rf_rd_addr", rf_rd_addr, exp_addr);
        chk("rf_rd_data", rf_rd_data, exp_data);
        chk("lq_count", lq_count, lq.size());
        chk("pend_mask", pend_mask, model_mask());
        $display("step av=%0b ard=%0d lv=%0b lrd=%0d -> we=%0b addr=%0d data=%08h cnt=%0d mask=%08h",
                 av, ard, lv, lrd, rf_we, rf_rd_addr, rf_rd_data, lq_count, pend_mask);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int i_ld;
        int cyc;
        int cnt_before;
        rst_n = 1'b0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0;  ld_rd = 0;  ld_data = 0;
        exp_we = 0; exp_addr = 0; exp_data = 0;
        #12;
        chk("rst_we", rf_we, 0);
        chk("rst_addr", rf_rd_addr, 0);
        chk("rst_data", rf_rd_data, 0);
        chk("rst_cnt", lq_count, 0);
        chk("rst_mask", pend_mask, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // ALU only
        step(1, 5, 32'hDEADBEEF, 0, 0, 0);
        idle();

        // Contention: ALU busy while loads to 7 and 9 queue, then drain
        step(1, 1, 32'h11, 1, 7, 32'h7777);
        step(1, 2, 32'h22, 1, 9, 32'h9999);
        step(1, 3, 32'h33, 0, 0, 0);
        chk("mask7", pend_mask[7], 1);
        chk("mask9", pend_mask[9], 1);
        idle(); idle(); idle();

        // Full queue: ALU held high, loads keep arriving
        cnt_before = model_ld_wr;
        dut_ld_wr = 0;
        for (int k = 0; k < 10; k++)
            step(1, 1, 32'hA000 + k, 1, 5'(8 + (k % 4)), 32'hB000 + k);
        for (int k = 0; k < 6; k++) idle();
        chk("full_ld_writes", dut_ld_wr, model_ld_wr - cnt_before);

        // rd = 0 drop on both sources
        step(1, 0, 32'hCAFE, 1, 0, 32'hF00D);
        idle();
        chk("x0_cnt", lq_count, 0);
        chk("x0_mask0", pend_mask[0], 0);

        // Reset mid-operation with 3 loads queued
        step(1, 1, 1, 1, 12, 32'hC1);
        step(1, 1, 2, 1, 13, 32'hC2);
        step(1, 1, 3, 1, 14, 32'hC3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_we", rf_we, 0);
        chk("mid_rst_cnt", lq_count, 0);
        chk("mid_rst_mask", pend_mask, 0);
        #1 rst_n = 1'b1;
        lq.delete();
        exp_we = 0; exp_addr = 0; exp_data = 0;
        idle(); idle();

        // Random wrap-around with duplicate destinations 3 and 4
        dut_ld_wr = 0; model_ld_wr = 0;
        i_ld = 0; cyc = 0;
        while (i_ld < 10 && cyc < 300) begin
            bit lv, av;
            lv = 1'($urandom_range(0, 1));
            av = 1'($urandom_range(0, 1));
            if (lv && lq.size() != 4) begin
                step(av, 5'($urandom_range(10, 31)), $urandom, 1, (i_ld % 2) ? 5'd4 : 5'd3, 32'h300 + i_ld);
                i_ld++;
            end else begin
                step(av, 5'($urandom_range(10, 31)), $urandom, lv, 5'd3, 32'hEEEE);
            end
            cyc++;
        end
        chk("rand_loads_sent", i_ld, 10);
        for (int k = 0; k < 20 && lq.size() != 0; k++) idle();
        idle();
        chk("rand_drain_cnt", lq_count, 0);
        chk("rand_ld_writes", dut_ld_wr, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
